// File: rtl/sbox_sched.sv
// Issue scheduler for the shared pipelined masked AES S-box: arbitrates state/key requesters,
// gates issue on fresh randomness, and tracks tag/source through the pipe. Define SBOX_SCHED_RR_EN for round-robin grants.
module sbox_sched #(
    parameter int LAT  = 3,
    parameter int TAGW = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            st_valid,
    input  logic [TAGW-1:0] st_tag,
    output logic            st_ready,
    input  logic            ks_valid,
    input  logic [TAGW-1:0] ks_tag,
    output logic            ks_ready,
    input  logic            rnd_valid,
    output logic            rnd_consume,
    output logic            sb_issue,
    output logic            sb_sel,
    output logic            out_valid,
    output logic            out_src,
    output logic [TAGW-1:0] out_tag,
    input  logic            flush,
    output logic            flush_done,
    output logic            busy
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic                     sel_q, sel_d;
    logic [LAT-1:0]           vld_q, vld_d;
    logic [LAT-1:0]           src_q, src_d;
    logic [LAT-1:0][TAGW-1:0] tag_q, tag_d;
    logic                     any_req, gsel, issue;

    assign any_req = st_valid | ks_valid;

    // sel_q doubles as the last-grant register: it is rewritten on every issue.
`ifdef SBOX_SCHED_RR_EN
    assign gsel = (st_valid & ks_valid) ? ~sel_q : ks_valid;
`else
    assign gsel = ks_valid;
`endif

    assign issue       = !RST && (state_q != FLUSH) && !flush && rnd_valid && any_req;
    assign sb_issue    = issue;
    assign rnd_consume = issue;
    assign ks_ready    = issue & gsel;
    assign st_ready    = issue & ~gsel;
    assign sb_sel      = issue ? gsel : sel_q;
    assign sel_d       = sb_sel;

    assign out_valid = vld_q[LAT-1];
    assign out_src   = src_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign busy      = (inflight_q != '0) || (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush)        state_d = FLUSH;
                else if (any_req) state_d = RUN;
            end
            RUN: begin
                if (flush)                                 state_d = FLUSH;
                else if (!any_req && (inflight_q == '0))   state_d = IDLE;
            end
            FLUSH: begin
                if (inflight_q == '0) begin
                    state_d    = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, out_valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Tag/source pipe advances unconditionally, matching the stall-free S-box.
    always_comb begin
        vld_d    = vld_q;
        src_d    = src_q;
        tag_d    = tag_q;
        vld_d[0] = issue;
        src_d[0] = sb_sel;
        tag_d[0] = gsel ? ks_tag : st_tag;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            src_d[i] = src_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            sel_q      <= 1'b0;
            vld_q      <= '0;
            src_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            sel_q      <= sel_d;
            vld_q      <= vld_d;
            src_q      <= src_d;
            tag_q      <= tag_d;
        end
    end
endmodule
